data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
// - Memory-side responder for the load/store port driven by the MEM stage.
// - Accepts level-held read/write requests, models a fixed access latency and
//   returns data or a write acknowledge as a one-cycle valid pulse.
// - Backs a word-organised synchronous data RAM with byte/half/word write lanes.
// - Sits between the core's MEM stage and the data memory macro / bus bridge.
// PARAMETERS
// - BITSIZE      32    data and address width; only 32 is supported.
// - DEPTH_WORDS  1024  RAM depth in 32-bit words (power of 2).
// - LATENCY      2     cycles from request sample to valid_o; must be >= 1.
// PORTS
// - clk            in   1        single clock; all logic on posedge clk.
// - rstn_i         in   1        asynchronous, active-low reset.
// - addr_i         in   BITSIZE  byte address of the access.
// - data_i         in   BITSIZE  store data, right-aligned (byte in [7:0]).
// - read_i         in   1        load request, level, held until serviced.
// - write_i        in   1        store request, level, held until serviced.
// - write_size_i   in   2        00 byte, 01 half, 10 word, 11 treated as word.
// - data_o         out  BITSIZE  load data (aligned word); 0 on store responses.
// - valid_o        out  1        one-cycle response pulse.
// - err_o          out  1        access error; present only with DMEM_ERR_EN.
// BEHAVIOUR
// - Reset: state IDLE, counter 0, valid_o=0, data_o=0, err_o=0. RAM contents
//   are not reset. A reset mid-access aborts it and no write is committed.
// - FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: write_i or read_i high -> latch addr, data, size, op; cnt=LATENCY-1.
//     write_i wins if both are high (the read is dropped, not queued).
//   BUSY: cnt decrements each cycle; at cnt==0 go to RESP. Input changes
//     while BUSY are ignored (values are latched).
//   RESP: valid_o=1 for exactly this cycle. Read: data_o=RAM[addr[..:2]].
//     Write: lanes commit on this edge and data_o=0. Always -> IDLE.
// - Latency: request high in cycle N -> valid_o in cycle N+LATENCY+1.
//   Back-to-back throughput is one access per LATENCY+2 cycles.
// - A request still high in the IDLE cycle after RESP starts a new access.
//   The initiator must drop its request in the valid_o cycle. Repeated
//   accesses are idempotent.
// - data_o holds its last value outside RESP; consumers qualify it with valid_o.
// - Write lanes use word index addr[log2(DEPTH_WORDS)+1:2].
//   byte: lane addr[1:0] <- data_i[7:0].
//   half: lanes {addr[1],0}+1..0 <- data_i[15:0].
//   word: all lanes <- data_i.
//   Untouched lanes keep their contents.
// - Address bits above the RAM range are ignored (wrap-around aliasing).
// - Misaligned half/word accesses use the truncated aligned address.
// CONFIGURATION
// - DMEM_ERR_EN defined: adds err_o.
//   err_o=1 with valid_o when a half access has addr[0]!=0, a word access has
//   addr[1:0]!=0, or the address is >= DEPTH_WORDS*4.
//   On error a write commits nothing and a read returns data_o=0.
//   err_o is 0 outside RESP.
// - DMEM_ERR_EN undefined: no err_o port. Truncation and aliasing as above,
//   with no error indication.
// TESTING
// - Word write 0xDEADBEEF @0x10, then read @0x10 -> valid_o 3 cycles after each
//   request (LATENCY=2), read data_o=0xDEADBEEF.
// - Word 0x11223344 @0x20, byte 0xAA @0x21, half 0xBBCC @0x22, read @0x20 ->
//   data_o=0xBBCCAA44.
// - read_i held high for 12 cycles @0x10 -> valid_o pulses every 4 cycles,
//   each pulse with the same data.
// - read_i and write_i both high, data 0x5 @0x30 -> write performed; a later
//   read @0x30 returns 0x5 and only one valid_o occurred.
// - rstn_i low during BUSY of a word write 0xFFFFFFFF @0x40 -> valid_o stays 0;
//   a read @0x40 after reset returns the old value.
// - With DMEM_ERR_EN: word write @0x13 -> err_o=1 with valid_o, RAM unchanged.
//   Read @DEPTH_WORDS*4 -> err_o=1, data_o=0.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the MEM-stage load/store port.
// Level-held read/write requests are latched, delayed by a fixed access
// latency, and answered with a one-cycle valid_o pulse. Backing storage is a
// word-organised synchronous RAM split into byte lanes so byte/half/word
// stores touch only their own lanes.
// Optional feature macro: DMEM_ERR_EN adds err_o (misaligned or out-of-range
// access flag). Without it, misaligned accesses truncate and high address
// bits alias silently.
module data_mem_responder #(
    parameter int BITSIZE     = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic [BITSIZE-1:0] addr_i,
    input  logic [BITSIZE-1:0] data_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [1:0]         write_size_i,
    output logic [BITSIZE-1:0] data_o,
    output logic               valid_o
`ifdef DMEM_ERR_EN
    ,
    output logic               err_o
`endif
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LANES = BITSIZE / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BITSIZE-1:0] addr_q, addr_d;
    logic [BITSIZE-1:0] wdata_q, wdata_d;
    logic [1:0]         size_q, size_d;
    logic               is_write_q, is_write_d;
    logic [BITSIZE-1:0] data_hold_q, data_hold_d;

    logic [AW-1:0]      word_idx;
    logic [LANES-1:0]   lane_be;
    logic [BITSIZE-1:0] lane_wdata;
    logic [BITSIZE-1:0] rd_word;
    logic [BITSIZE-1:0] resp_data;
    logic               access_err;
    logic               commit_wr;

    // Address bits above the RAM range are dropped here, giving wrap-around
    // aliasing; the two low bits only steer lanes.
    assign word_idx = addr_q[AW+1:2];

`ifdef DMEM_ERR_EN
    // Alignment is judged by the size presented with the request (reads too),
    // and any set bit above the RAM range marks the access out of range.
    assign access_err = ((size_q == 2'b01) && addr_q[0])
                     || (size_q[1] && (addr_q[1:0] != 2'b00))
                     || (addr_q[BITSIZE-1:AW+2] != '0);
    assign err_o      = (state_q == S_RESP) && access_err;
`else
    logic unused_high_addr;
    assign unused_high_addr = ^addr_q[BITSIZE-1:AW+2];
    assign access_err       = 1'b0;
`endif

    // Lanes are committed in the response cycle only, so a reset during BUSY
    // (which forces IDLE asynchronously) can never leave a partial store.
    assign commit_wr = (state_q == S_RESP) && is_write_q && !access_err;

    // Steer store data onto byte lanes: narrow data is replicated so each
    // enabled lane simply takes its own slice.
    always_comb begin
        lane_be    = '0;
        lane_wdata = wdata_q;
        case (size_q)
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_byte_q;

            // One byte lane of the RAM: gated write, registered read every cycle
            // (the read address is stable from the latch through RESP).
            always_ff @(posedge clk) begin
                if (commit_wr && lane_be[gi]) begin
                    lane_mem[word_idx] <= lane_wdata[gi*8 +: 8];
                end
                rd_byte_q <= lane_mem[word_idx];
            end

            assign rd_word[gi*8 +: 8] = rd_byte_q;
        end
    endgenerate

    assign resp_data = (is_write_q || access_err) ? '0 : rd_word;
    assign valid_o   = (state_q == S_RESP);
    assign data_o    = (state_q == S_RESP) ? resp_data : data_hold_q;

    // Next-state logic: latch the request in IDLE, count down the latency in
    // BUSY, present the response for exactly one cycle in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        is_write_d  = is_write_q;
        data_hold_d = data_hold_q;
        case (state_q)
            S_IDLE: begin
                if (write_i || read_i) begin
                    addr_d     = addr_i;
                    wdata_d    = data_i;
                    size_d     = write_size_i;
                    // A store wins when both are raised; the load is dropped.
                    is_write_d = write_i;
                    cnt_d      = CW'(LATENCY - 1);
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                data_hold_d = resp_data;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            is_write_q  <= 1'b0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            is_write_q  <= is_write_d;
            data_hold_q <= data_hold_d;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder with a
// byte-addressed reference memory model and randomized loads/stores.
module tb_data_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int NB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr_i, data_i, data_o;
    logic        read_i, write_i, valid_o;
    logic [1:0]  size_i;
`ifdef DMEM_ERR_EN
    logic        err_o;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(
        .BITSIZE    (32),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .read_i      (read_i),
        .write_i     (write_i),
        .write_size_i(size_i),
        .data_o      (data_o),
        .valid_o     (valid_o)
`ifdef DMEM_ERR_EN
        ,
        .err_o       (err_o)
`endif
    );

    // Reference model: plain byte memory, address taken modulo the RAM size.
    logic [7:0]  mb [NB];
    logic [31:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;
    int          valid_cnt = 0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int b;
        b = int'(a % NB) & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] sz);
        int b;
        b = int'(a % NB);
        if (sz == 2'b00) begin
            mb[b] = d[7:0];
        end else if (sz == 2'b01) begin
            b = b & ~1;
            mb[b]   = d[7:0];
            mb[b+1] = d[15:8];
        end else begin
            b = b & ~3;
            mb[b]   = d[7:0];
            mb[b+1] = d[15:8];
            mb[b+2] = d[23:16];
            mb[b+3] = d[31:24];
        end
    endfunction

    function automatic void check(input string nm, input logic [31:0] got,
                                  input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && valid_o) begin
            valid_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid got data=%h exp no response", data_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    fails++;
                    $display("FAIL rsp_data got=%h exp=%h", data_o, e);
                end else begin
                    $display("[TB] rsp data=%h", data_o);
                end
            end
        end
    end

    // One access: push expectation, hold request until valid_o, drop, idle one cycle.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz,
                          input bit use_ovr, input logic [31:0] ovr);
        int k;
        if (wr) begin
            model_write(a, d, sz);
            exp_q.push_back(32'h0);
        end else begin
            exp_q.push_back(use_ovr ? ovr : model_read(a));
        end
        addr_i  = a;
        data_i  = d;
        size_i  = sz;
        write_i = wr;
        read_i  = rd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!valid_o && k < 20);
        write_i = 1'b0;
        read_i  = 1'b0;
        check("latency", 32'(k), 32'(LAT + 1));
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p[$];
        int v0;
        rstn    = 1'b0;
        addr_i  = '0;
        data_i  = '0;
        read_i  = 1'b0;
        write_i = 1'b0;
        size_i  = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_data", data_o, 32'h0);
        rstn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Known contents for the region used below (RAM itself is not reset).
        for (int i = 0; i < 32; i++) access(1'b1, 1'b0, 32'(i * 4), 32'h0, 2'b10, 1'b0, 32'h0);

        // Word store then load.
        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0);
        access(1'b0, 1'b1, 32'h10, 32'h0, 2'b10, 1'b1, 32'hDEADBEEF);

        // Lane merging.
        access(1'b1, 1'b0, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'h0);
        access(1'b1, 1'b0, 32'h21, 32'h000000AA, 2'b00, 1'b0, 32'h0);
        access(1'b1, 1'b0, 32'h22, 32'h0000BBCC, 2'b01, 1'b0, 32'h0);
        access(1'b0, 1'b1, 32'h20, 32'h0, 2'b10, 1'b1, 32'hBBCCAA44);

        // Held read: pulses every LAT+2 cycles, same data each time.
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hDEADBEEF);
        addr_i = 32'h10;
        read_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (valid_o) p.push_back(k);
        end
        read_i = 1'b0;
        @(negedge clk);
        check("held_pulses", 32'(p.size()), 32'd3);
        for (int i = 0; i < p.size() && i < 3; i++)
            check("held_pos", 32'(p[i]), 32'(LAT + 1 + i * (LAT + 2)));

        // Both raised: store wins, single response.
        v0 = valid_cnt;
        access(1'b1, 1'b1, 32'h30, 32'h5, 2'b10, 1'b0, 32'h0);
        check("both_one_valid", 32'(valid_cnt - v0), 32'd1);
        access(1'b0, 1'b1, 32'h30, 32'h0, 2'b10, 1'b1, 32'h5);

        // Reset during BUSY aborts the store.
        addr_i  = 32'h40;
        data_i  = 32'hFFFFFFFF;
        size_i  = 2'b10;
        write_i = 1'b1;
        repeat (2) @(negedge clk);
        rstn    = 1'b0;
        write_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(valid_o), 32'h0);
        end
        check("rst_mid_data", data_o, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        access(1'b0, 1'b1, 32'h40, 32'h0, 2'b10, 1'b1, 32'h0);

        // Randomized traffic: aliased high bits, all sizes, misaligned offsets.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] hi, a, d;
            logic [4:0]  idx;
            logic [1:0]  lo, sz;
            bit          wr, rd;
            hi  = $urandom;
            idx = 5'($urandom_range(0, 31));
            lo  = 2'($urandom_range(0, 3));
            sz  = 2'($urandom_range(0, 3));
            d   = $urandom;
            wr  = ($urandom_range(0, 1) == 1);
            rd  = !wr || ($urandom_range(0, 3) == 0);
            a   = {hi[19:0], 5'b0, idx, lo};
            access(wr, rd, a, d, sz, 1'b0, 32'h0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
